// File: rtl/mem_pckg.sv
// Shared definitions for the memory-controller side blocks.
// Read-latency helper and the read-streamer state type.
package mem_pckg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_strm_state_t;

    // Cycles from rd_en to data_out: input stages + BRAM read + output stages.
    function automatic int rd_latency(input int pipe_in, input int pipe_out);
        return pipe_in + pipe_out + 1;
    endfunction

endpackage

// File: rtl/mem_rd_fifo.sv
// Shift-register return buffer: the head entry is always slot 0, so the
// outputs come straight from flops and stay put while nothing is popped.
module mem_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WDT   = 33
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WDT-1:0]               din,
    input  logic                         pop,
    output logic [WDT-1:0]               dout,
    output logic                         dout_vld,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WDT-1:0]   mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic             do_pop;
    logic [CNT_W-1:0] wr_idx;

    assign do_pop   = pop & vld[0];
    // A simultaneous pop shifts everything down, so the free slot is one lower.
    assign wr_idx   = do_pop ? count - CNT_W'(1) : count;
    assign dout     = mem[0];
    assign dout_vld = vld[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            vld   <= '0;
            count <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH-1; i++) begin
                    mem[i] <= mem[i+1];
                    vld[i] <= vld[i+1];
                end
                vld[DEPTH-1] <= 1'b0;
            end
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == wr_idx) begin
                        mem[i] <= din;
                        vld[i] <= 1'b1;
                    end
                end
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/mem_rd_streamer.sv
// Read-side streamer: issues base..base+len-1 reads under a credit limit,
// tracks the fixed memory latency and buffers returns into a valid/ready stream.
module mem_rd_streamer
    import mem_pckg::*;
#(
    parameter int RD_ADDR_WDT  = 10,
    parameter int DATA_OUT_WDT = 32,
    parameter int PIPE_IN_CNT  = 1,
    parameter int PIPE_OUT_CNT = 1,
    parameter int FIFO_DEPTH   = PIPE_IN_CNT + PIPE_OUT_CNT + 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_start,
    input  logic [RD_ADDR_WDT-1:0]  cmd_base_addr,
    input  logic [RD_ADDR_WDT:0]    cmd_len,
    output logic                    cmd_ready,
    output logic                    busy,
    output logic [RD_ADDR_WDT-1:0]  rd_addr,
    output logic                    rd_en,
    input  logic [DATA_OUT_WDT-1:0] data_out,
    output logic                    wr_en,
    output logic [DATA_OUT_WDT-1:0] strm_data,
    output logic                    strm_valid,
    input  logic                    strm_ready,
    output logic                    strm_last
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // ISSUE | issuing reads while credit allows
    // DRAIN | all reads issued, streaming the remaining returns

    localparam int LAT   = rd_latency(PIPE_IN_CNT, PIPE_OUT_CNT);
    localparam int CNT_W = $clog2(FIFO_DEPTH+1);
    localparam int SUM_W = CNT_W + 2;
    localparam int LEN_W = RD_ADDR_WDT + 1;

    rd_strm_state_t         state;
    logic [LEN_W-1:0]       rem;
    logic [LEN_W-1:0]       rem_after;
    logic [LAT-1:0]         vsr;
    logic [LAT-1:0]         lsr;
    logic [CNT_W-1:0]       inflight;
    logic [CNT_W-1:0]       fifo_cnt;
    logic [DATA_OUT_WDT:0]  fifo_dout;
    logic                   fifo_vld;
    logic                   push;
    logic                   pop;
    logic                   issue_last;
    logic [SUM_W-1:0]       sum_next;
    logic                   credit_ok;

    assign wr_en      = 1'b0;
    assign push       = vsr[LAT-1];
    assign pop        = fifo_vld & strm_ready;
    assign strm_valid = fifo_vld;
    assign strm_data  = fifo_dout[DATA_OUT_WDT-1:0];
    assign strm_last  = fifo_vld & fifo_dout[DATA_OUT_WDT];
    assign issue_last = rd_en & (rem == LEN_W'(1));
    assign rem_after  = rem - LEN_W'(rd_en);

    // rd_en is registered, so credit is judged on next cycle's occupancy:
    // the read going out now counts, a pop happening now frees a slot.
    assign sum_next  = SUM_W'(inflight) + SUM_W'(fifo_cnt) + SUM_W'(rd_en);
    assign credit_ok = sum_next < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            rem       <= '0;
            vsr       <= '0;
            lsr       <= '0;
            inflight  <= '0;
        end else begin
            vsr[0] <= rd_en;
            lsr[0] <= issue_last;
            for (int i = 1; i < LAT; i++) begin
                vsr[i] <= vsr[i-1];
                lsr[i] <= lsr[i-1];
            end

            case ({rd_en, push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase

            if (rd_en) begin
                rd_addr <= rd_addr + RD_ADDR_WDT'(1);
                rem     <= rem_after;
            end

            case (state)
                IDLE: begin
                    rd_en <= 1'b0;
                    if (cmd_start && cmd_len != '0) begin
                        state     <= ISSUE;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        rd_addr   <= cmd_base_addr;
                        rem       <= cmd_len;
                        rd_en     <= 1'b1;
                    end
                end
                ISSUE: begin
                    rd_en <= (rem_after != '0) && credit_ok;
                    if (issue_last) state <= DRAIN;
                end
                DRAIN: begin
                    rd_en <= 1'b0;
                    if (pop && strm_last) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    rd_en     <= 1'b0;
                end
            endcase
        end
    end

    mem_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WDT   (DATA_OUT_WDT + 1)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      ({lsr[LAT-1], data_out}),
        .pop      (pop),
        .dout     (fifo_dout),
        .dout_vld (fifo_vld),
        .count    (fifo_cnt)
    );

endmodule

// File: tb/tb_mem_rd_streamer.sv
// Bench for mem_rd_streamer: a latency-L memory model, queue-based expected
// stream and a credit model checked every cycle, driven by a vector table and random commands.
module tb_mem_rd_streamer;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int PI    = 1;
    localparam int PO    = 1;
    localparam int LAT   = PI + PO + 1;
    localparam int DEPTH = PI + PO + 2;
    localparam int NV    = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_start;
    logic [AW-1:0] cmd_base_addr;
    logic [AW:0]   cmd_len;
    logic          cmd_ready;
    logic          busy;
    logic [AW-1:0] rd_addr;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          wr_en;
    logic [DW-1:0] strm_data;
    logic          strm_valid;
    logic          strm_ready;
    logic          strm_last;

    mem_rd_streamer #(
        .RD_ADDR_WDT  (AW),
        .DATA_OUT_WDT (DW),
        .PIPE_IN_CNT  (PI),
        .PIPE_OUT_CNT (PO),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_start     (cmd_start),
        .cmd_base_addr (cmd_base_addr),
        .cmd_len       (cmd_len),
        .cmd_ready     (cmd_ready),
        .busy          (busy),
        .rd_addr       (rd_addr),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .wr_en         (wr_en),
        .strm_data     (strm_data),
        .strm_valid    (strm_valid),
        .strm_ready    (strm_ready),
        .strm_last     (strm_last)
    );

    initial forever #5 clk = ~clk;

    // Memory: data_out shows mem_img[addr] L cycles after the address was presented.
    logic [DW-1:0] mem_img [1<<AW];
    logic [AW-1:0] mp [LAT];
    always @(posedge clk) begin
        mp[0] <= rd_addr;
        for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
    end
    assign data_out = mem_img[mp[LAT-1]];

    typedef struct {
        logic [AW-1:0] base;
        int            len;
        int            mode;        // 0 ready high, 1 stall from first beat, 2 random ready
        int            stall;
        bit            poke;        // pulse cmd_start mid-transfer
        int            exp_first;   // cycle of first strm_valid, 0 = not checked
        int            exp_lat;     // cycle of last beat, 0 = not checked
        int            exp_issued;  // reads issued when a stall releases, 0 = not checked
    } vec_t;

    vec_t          vecs [NV];
    logic [AW-1:0] addr_q [$];
    logic [DW:0]   exp_q  [$];
    int            outstanding;
    int            n_issued;
    int            n_checks;
    int            n_errors;
    bit            mon_en;
    bit            prev_hold;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          mon_exp_rd;
    logic [DW:0]   mon_e;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: reads go out exactly when words remain and fewer than
    // DEPTH words are outstanding (issued but not yet accepted downstream).
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            mon_exp_rd = (addr_q.size() > 0) && (outstanding < DEPTH);
            check("rd_en_credit", rd_en, mon_exp_rd);
            check("wr_en", wr_en, 1'b0);
            if (rd_en && addr_q.size() > 0) check("rd_addr", rd_addr, addr_q.pop_front());
            if (rd_en) begin
                n_issued++;
                outstanding++;
            end
            if (prev_hold) begin
                check("hold_valid", strm_valid, 1'b1);
                check("hold_data", strm_data, prev_data);
                check("hold_last", strm_last, prev_last);
            end
            if (strm_valid && strm_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL spurious_beat: got data 0x%0h expected no beat at %0t", strm_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("strm_data", strm_data, mon_e[DW-1:0]);
                    check("strm_last", strm_last, mon_e[DW]);
                end
                outstanding--;
            end
            prev_hold = strm_valid && !strm_ready;
            prev_data = strm_data;
            prev_last = strm_last;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic run_cmd(input vec_t v);
        int cyc, first, stall_left;
        bit done, stalling;
        check("cmd_ready_before", cmd_ready, 1'b1);
        cmd_start     = 1'b1;
        cmd_base_addr = v.base;
        cmd_len       = (AW+1)'(v.len);
        @(posedge clk); #1;
        cmd_start = 1'b0;
        n_issued  = 0;
        for (int i = 0; i < v.len; i++) begin
            addr_q.push_back(AW'(v.base + i));
            exp_q.push_back({(i == v.len-1), mem_img[AW'(v.base + i)]});
        end
        cyc = 1; first = 0; done = 0; stalling = 0; stall_left = v.stall;
        while (!done && cyc < 5000) begin
            if (v.mode == 2) begin
                strm_ready = 1'($urandom_range(0, 1));
            end else if (v.mode == 1 && stall_left > 0 && (stalling || strm_valid)) begin
                stalling   = 1;
                strm_ready = 1'b0;
                stall_left--;
            end else begin
                if (stalling && v.exp_issued != 0) check("issued_during_stall", n_issued, v.exp_issued);
                stalling   = 0;
                strm_ready = 1'b1;
            end
            if (v.poke && cyc == 2) begin
                cmd_start     = 1'b1;
                cmd_base_addr = ~v.base;
                cmd_len       = (AW+1)'(7);
            end else begin
                cmd_start = 1'b0;
            end
            @(negedge clk);
            if (cyc == 1) begin
                check("busy_running", busy, 1'b1);
                check("cmd_ready_running", cmd_ready, 1'b0);
            end
            if (strm_valid && first == 0) first = cyc;
            if (strm_valid && strm_ready && strm_last) done = 1;
            @(posedge clk); #1;
            cyc++;
        end
        check("cmd_completed", done, 1'b1);
        if (v.exp_first != 0) check("first_valid_cycle", first, v.exp_first);
        if (v.exp_lat != 0) check("last_beat_cycle", cyc - 1, v.exp_lat);
        check("cmd_ready_after", cmd_ready, 1'b1);
        check("busy_after", busy, 1'b0);
        strm_ready = 1'b1;
    endtask

    initial begin
        vec_t rv;
        int   beats;
        rst_n = 1'b0; cmd_start = 1'b0; cmd_base_addr = '0; cmd_len = '0;
        strm_ready = 1'b0; mon_en = 0; outstanding = 0; n_issued = 0;
        n_checks = 0; n_errors = 0;
        for (int i = 0; i < (1<<AW); i++) mem_img[i] = DW'(i) ^ 32'h0000_A5A5;

        //          base    len  mode stall poke first lat issued
        vecs[0] = '{10'h010,   4,  0,  0,  0,  5,  8, 0};
        vecs[1] = '{10'h3FE,   4,  0,  0,  0,  5,  8, 0};
        vecs[2] = '{10'h123,   1,  0,  0,  0,  5,  5, 0};
        vecs[3] = '{10'h200,  16,  1, 12,  0,  5,  0, DEPTH};
        vecs[4] = '{10'h050,  10,  0,  0,  1,  5,  0, 0};
        vecs[5] = '{10'h000,   3,  0,  0,  0,  5,  7, 0};
        vecs[6] = '{10'h3FF, 1024, 0,  0,  0,  5,  0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rd_en", rd_en, 1'b0);
        check("rst_rd_addr", rd_addr, '0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_strm_valid", strm_valid, 1'b0);
        check("rst_strm_last", strm_last, 1'b0);
        check("rst_strm_data", strm_data, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1; strm_ready = 1'b1;

        for (int k = 0; k < NV; k++) run_cmd(vecs[k]);

        // Zero-length command must be ignored.
        cmd_start = 1'b1; cmd_base_addr = 10'h055; cmd_len = '0;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zero_len_ready", cmd_ready, 1'b1);
            check("zero_len_rd_en", rd_en, 1'b0);
            @(posedge clk); #1;
        end

        // Reset in the middle of an 8-word command, after its 3rd beat.
        cmd_start = 1'b1; cmd_base_addr = 10'h080; cmd_len = (AW+1)'(8);
        @(posedge clk); #1;
        cmd_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr_q.push_back(AW'(10'h080 + i));
            exp_q.push_back({(i == 7), mem_img[AW'(10'h080 + i)]});
        end
        beats = 0;
        for (int c = 0; c < 50 && beats < 3; c++) begin
            @(negedge clk);
            if (strm_valid && strm_ready) beats++;
            @(posedge clk); #1;
        end
        check("mid_reset_beats_seen", beats, 3);
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", rd_en, 1'b0);
        check("mid_rst_rd_addr", rd_addr, '0);
        check("mid_rst_strm_valid", strm_valid, 1'b0);
        check("mid_rst_strm_last", strm_last, 1'b0);
        check("mid_rst_strm_data", strm_data, '0);
        addr_q.delete();
        exp_q.delete();
        outstanding = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1;
        rv = '{10'h100, 2, 0, 0, 0, 5, 6, 0};
        run_cmd(rv);
        repeat (8) @(posedge clk);
        #1;
        check("post_reset_quiet", strm_valid, 1'b0);

        // Random commands against a random memory image and random backpressure.
        for (int i = 0; i < (1<<AW); i++) mem_img[i] = $urandom;
        for (int n = 0; n < 25; n++) begin
            rv = '{AW'($urandom_range(0, (1<<AW)-1)), int'($urandom_range(1, 40)), 2, 0,
                   1'($urandom_range(0, 1)), 0, 0, 0};
            run_cmd(rv);
        end

        repeat (5) @(posedge clk);
        #1;
        check("final_idle", cmd_ready, 1'b1);
        check("final_no_valid", strm_valid, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
